// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing the data memory between two requesters.
// Optional bounded burst lock enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [1:0]  req_lock,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_err,
  output logic [31:0] req_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE0,
    SERVE1
  } state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state, state_nxt;
  logic        last, last_nxt;
  logic        serving;
  logic        sel;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_valid;
  logic        cur_write;
  logic        cur_bad;
  logic        stay;

  assign serving   = (state != IDLE);
  assign sel       = (state == SERVE1);
  assign cur_addr  = sel ? req_addr1 : req_addr0;
  assign cur_wdata = sel ? req_wdata1 : req_wdata0;
  assign cur_valid = req_valid[sel];
  assign cur_write = req_write[sel];
  assign cur_bad   = (|cur_addr[1:0]) ||
                     (cur_addr[31:2] >= DEPTH_W);

`ifdef DMEM_ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LIM = BW'(MAX_BURST - 1);

  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          oth_valid;

  assign oth_valid = sel ? req_valid[0] : req_valid[1];
  assign stay = cur_valid && req_lock[sel] &&
                ((burst_cnt < LIM) || !oth_valid);

  // Burst counter: cleared outside a locked run, saturates at all-ones.
  always_comb begin
    burst_nxt = '0;
    if (serving && stay) begin
      burst_nxt = (&burst_cnt) ? burst_cnt
                               : burst_cnt + BW'(1);
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) burst_cnt <= '0;
    else       burst_cnt <= burst_nxt;
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign stay = 1'b0;
`endif

  // Next state: round-robin grant from IDLE, optional locked stay.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (req_valid[0] && (!req_valid[1] || last)) begin
          state_nxt = SERVE0;
          last_nxt  = 1'b0;
        end else if (req_valid[1]) begin
          state_nxt = SERVE1;
          last_nxt  = 1'b1;
        end
      end
      SERVE0, SERVE1: begin
        state_nxt = stay ? state : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and last-grant registers; last=1 lets requester 0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Memory strobes and requester responses driven from the served port.
  always_comb begin
    req_ack        = '0;
    req_err        = '0;
    req_rdata      = '0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (serving) begin
      mem_addr       = cur_addr;
      mem_write_data = cur_wdata;
      if (cur_valid) begin
        req_ack[sel] = 1'b1;
        req_err[sel] = cur_bad;
        if (!cur_bad) begin
          mem_write = cur_write;
          mem_read  = !cur_write;
          if (!cur_write) req_rdata = mem_read_data;
        end
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported data memory between the CPU datapath (requester 0) and a debug/DMA loader (requester 1). It sequences every access through a small state machine, drives the memory's `MemRead`/`MemWrite` strobes and returns read data plus a one-cycle acknowledge to the winning requester. Arbitration is round-robin, with an optional bounded lock for back-to-back bursts. It sits between the requesters and `data_memory`, and is the only driver of that memory's inputs.

## Interface
- `DEPTH`, 16: memory depth in 32-bit words; word index `addr[31:2]` must be < `DEPTH`.
- `MAX_BURST`, 8: maximum consecutive locked grants to one requester while the other is waiting (≥1).
- `clk` in 1: the design clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid[1:0]` in 2: access request per requester; held until `req_ack` for that requester.
- `req_write[1:0]` in 2: 1 = store, 0 = load.
- `req_lock[1:0]` in 2: keep the grant after this access (lock feature only).
- `req_addr0`, `req_addr1` in 32: byte address.
- `req_wdata0`, `req_wdata1` in 32: store data.
- `req_ack[1:0]` out 2: one-cycle completion pulse.
- `req_err[1:0]` out 2: qualifies `req_ack`; access was misaligned or out of range.
- `req_rdata` out 32: load data, valid in the `req_ack` cycle of a load; 0 otherwise.
- `mem_addr` out 32, `mem_write_data` out 32, `mem_read` out 1, `mem_write` out 1: to memory `addr`, `write_data`, `MemRead`, `MemWrite`.
- `mem_read_data` in 32: from memory `read_data` (combinational).

## Operation
- States: `IDLE`, `SERVE0`, `SERVE1`. Registers: `state`, `last` (last granted requester), `burst_cnt` (width clog2(MAX_BURST)+1).
- `IDLE`: no strobes, no ack. One valid → go to `SERVEn` for it. Both valid → grant `!last`. `last` updates on entry to `SERVEn`. `burst_cnt` clears.
- `SERVEn`: memory signals driven combinationally from requester n. If `req_valid[n]`=1, `req_ack[n]`=1 this cycle.
  - Store: `mem_write`=1, committed at the closing edge.
  - Load: `mem_read`=1, `req_rdata`=`mem_read_data`.
- Error: `addr[1:0]`≠0 or `addr[31:2]`≥`DEPTH` → ack with `req_err[n]`=1, `mem_read`=`mem_write`=0, `req_rdata`=0.
- Leaving `SERVEn`:
  - If `req_valid[n]`=1, `req_lock[n]`=1, and either `burst_cnt`<`MAX_BURST`-1 or the other requester is idle → stay in `SERVEn`, `burst_cnt`++ (saturating).
  - Otherwise → `IDLE`.
- Abort: `req_valid[n]` dropped while in `SERVEn` → no ack, no strobes, next state `IDLE`.
- In `IDLE`, `mem_addr` and `mem_write_data` are 0. At most one bit of `req_ack` is high in any cycle.

## Timing
- Reset (async, immediate): `state`=`IDLE`, `last`=1 (so requester 0 wins the first tie), `burst_cnt`=0, all outputs 0.
- Reset asserted during `SERVEn`: strobes drop immediately. The access is lost; the requester re-issues it.
- Latency: request seen in `IDLE` at edge k → ack during cycle k+1. Store is visible to a load starting at k+2.
- Throughput:
  - Unlocked: one access per 2 cycles per requester.
  - Locked: one access per cycle, up to `MAX_BURST` consecutive when contended.
- Requester inputs must be stable from assertion until ack. New request values may be presented in the cycle after ack.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: lock and burst behaviour as above.
- Not defined: `req_lock` is ignored and `burst_cnt` is not implemented. Every `SERVEn` returns to `IDLE`.

## Test plan
- Reset, then requester 0 loads addr 0x4 (memory preloaded with 20) → `req_ack[0]` one cycle later, `req_rdata`=20, `req_err`=0.
- Requester 1 stores 0xDEAD to 0x8, then loads 0x8 → second ack returns 0xDEAD. Store ack cycle shows `mem_write`=1 and `mem_addr`=8.
- Both valid continuously, unlocked → grants alternate 0,1,0,1; never two acks in one cycle.
- Lock enabled, `MAX_BURST`=4, requester 0 locked, requester 1 waiting → exactly 4 consecutive acks to 0, then `IDLE`, then requester 1 granted.
- Addresses 0x40 and 0x6 → ack with `req_err`=1, `mem_read`=`mem_write`=0, memory contents unchanged.
- `reset` pulsed mid-store in `SERVE1` → `mem_write` drops in the same cycle, memory unchanged, `state`=`IDLE`, `req_ack`=0.
